// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and constants for the integer register file
package regfile_pkg;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;
    localparam logic [RegBus-1:0] ZeroWord = '0;
endpackage

// File: rtl/regfile.sv
// regfile: 32x32 register file, one synchronous write port, two combinational read ports with write bypass
module regfile
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [RegAddrBus-1:0] waddr,
    input  logic [RegBus-1:0]     wdata,
    input  logic                  re1,
    input  logic [RegAddrBus-1:0] raddr1,
    output logic [RegBus-1:0]     rdata1,
    input  logic                  re2,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic [RegBus-1:0]     rdata2
);
    logic [RegBus-1:0] regs [RegNum];

    always_ff @(posedge clk)
        if (rst) for (int i = 0; i < RegNum; i++) regs[i] <= ZeroWord;
        else if (we && waddr != '0) regs[waddr] <= wdata;

    // r0 and disabled ports read zero ahead of the same-cycle bypass
    assign rdata1 = (rst || raddr1 == '0 || !re1) ? ZeroWord :
                    (we && raddr1 == waddr) ? wdata : regs[raddr1];
    assign rdata2 = (rst || raddr2 == '0 || !re2) ? ZeroWord :
                    (we && raddr2 == waddr) ? wdata : regs[raddr2];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scoreboard bench for regfile
module tb_regfile;
    logic        clk = 0, rst = 1, we = 0, re1 = 0, re2 = 0;
    logic [4:0]  waddr = 0, raddr1 = 0, raddr2 = 0;
    logic [31:0] wdata = 0, rdata1, rdata2;
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    int passes = 0, total = 0;

    regfile dut (.clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
                 .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
                 .re2(re2), .raddr2(raddr2), .rdata2(rdata2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // drive one cycle's inputs mid-cycle, queue expectations, compare before the next rising edge
    task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                       input logic [31:0] x1, input logic [31:0] x2, input string tag);
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        q1.push_back(x1);
        q2.push_back(x2);
        #1;
        chk({tag, "_p1"}, rdata1, q1.pop_front());
        chk({tag, "_p2"}, rdata2, q2.pop_front());
    endtask

    initial begin
        cyc(1, 0, 0, 0, 1, 1, 1, 2, 0, 0, "rst0");
        cyc(1, 1, 4, 32'h5555_5555, 1, 4, 1, 4, 0, 0, "rst1");
        for (int i = 1; i < 32; i++)
            cyc(0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i + 1), 0, 0, "post_rst");
        cyc(0, 1, 5, 32'hDEADBEEF, 1, 5, 1, 6, 32'hDEADBEEF, 0, "wr_r5");
        cyc(0, 0, 0, 0, 1, 5, 1, 6, 32'hDEADBEEF, 0, "rd_r5");
        cyc(0, 1, 7, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 0, "wr_r7");
        cyc(0, 0, 0, 0, 1, 7, 1, 7, 32'hAAAAAAAA, 32'hAAAAAAAA, "rd_r7_old");
        cyc(0, 1, 7, 32'h12345678, 1, 7, 1, 7, 32'h12345678, 32'h12345678, "bypass_r7");
        cyc(0, 0, 0, 0, 1, 7, 1, 5, 32'h12345678, 32'hDEADBEEF, "rd_r7_new");
        cyc(0, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, "wr_r0");
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "rd_r0");
        cyc(0, 1, 3, 32'h42, 0, 0, 0, 0, 0, 0, "wr_r3");
        cyc(0, 0, 0, 0, 1, 3, 0, 3, 32'h42, 0, "re2_off");
        cyc(0, 0, 0, 0, 0, 3, 1, 3, 0, 32'h42, "re2_on");
        cyc(0, 1, 3, 32'h99, 0, 3, 1, 3, 0, 32'h99, "bypass_gated");
        cyc(0, 1, 10, 32'h1, 1, 10, 1, 10, 32'h1, 32'h1, "b2b_1");
        cyc(0, 1, 10, 32'h2, 1, 10, 1, 3, 32'h2, 32'h99, "b2b_2");
        cyc(0, 0, 0, 0, 1, 10, 1, 10, 32'h2, 32'h2, "b2b_rd");
        cyc(0, 1, 9, 32'h11111111, 0, 0, 0, 0, 0, 0, "wr_r9");
        cyc(0, 0, 0, 0, 1, 9, 1, 9, 32'h11111111, 32'h11111111, "rd_r9");
        cyc(1, 1, 9, 32'h22222222, 1, 9, 1, 5, 0, 0, "rst_wr_r9");
        cyc(0, 0, 0, 0, 1, 9, 1, 5, 0, 0, "rd_r9_after_rst");
        cyc(0, 0, 0, 0, 1, 7, 1, 10, 0, 0, "rd_after_rst");
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage integer pipeline: 32 × 32-bit architectural registers, one synchronous write port and two asynchronous read ports. The write port consumes the destination triple (address, write-enable, data) that the access stage forwards through the access/write-back pipeline register. The read ports serve the decode stage. Same-cycle write-to-read bypass lets decode see a value in the same cycle it is being retired.

## Interface
- No parameters. Widths come from the shared defines.
  - `RegBus`: 32 bits.
  - `RegAddrBus`: 5 bits.
  - `RegNum`: 32.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high (`RstEnable` = 1).
- `we` input 1: write enable from write-back (`WriteEnable` = 1).
- `waddr` input `RegAddrBus`: destination register index.
- `wdata` input `RegBus`: value to write.
- `re1` input 1: read-port-1 enable (`ReadEnable` = 1).
- `raddr1` input `RegAddrBus`: read-port-1 index.
- `rdata1` output `RegBus`: read-port-1 data, combinational.
- `re2`, `raddr2`, `rdata2`: identical second read port.

## Operation
- Storage is `regs[0..31]`, each `RegBus` wide.
- Write, on the rising edge of `clk`:
  - `rst` = 1: all 32 entries cleared to `ZeroWord`; `we` ignored.
  - Else if `we` = 1 and `waddr` ≠ 0: `regs[waddr]` ← `wdata`.
  - Else: no change.
  - Writes to r0 are silently dropped; r0 always reads 0.
- Read, per port n (combinational, evaluated in priority order):
  1. `rst` = 1 → `rdata`n = `ZeroWord`.
  2. `raddr`n = 0 → `ZeroWord`.
  3. `re`n = 1 and `we` = 1 and `raddr`n = `waddr` → `wdata` (bypass).
  4. `re`n = 1 → `regs[raddr`n`]`.
  5. `re`n = 0 → `ZeroWord`.
- The two ports are fully independent. Both may hit the same index, and both may bypass the same write.
- No X propagation: every output has a defined value for every input combination.

## Timing
- Write latency: a value presented with `we` = 1 in cycle N is stored at the end of cycle N.
  - Cycle N: visible via bypass.
  - Cycle N+1 onward: visible from storage.
- Read latency: zero cycles, combinational from `raddr`n/`re`n/`we`/`waddr`/`wdata`.
- Reset value of outputs: `rdata1` = `rdata2` = `ZeroWord` for every cycle `rst` is high.
- Storage is zero from the first edge after `rst` rises.
- Reset mid-operation: a write presented in the same cycle as `rst` = 1 is lost. The next cycle reads 0 from that register.
- Simultaneous write and read of r0 with `we` = 1: the read returns 0 (rule 2 beats bypass), and storage is unchanged.
- Back-to-back writes to the same index: the last write wins; each cycle's bypass shows that cycle's `wdata`.

## Structure
- Shared defines header (already present) carries:
  - `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`
  - `ZeroWord`, `NOPRegAddr`
  - `RstEnable`, `WriteEnable`, `ReadEnable`
- No new package contents needed.
- Single module; no sub-module.
- The two read ports are identical logic. A per-port function or generate loop is acceptable, but a separate sub-module is not warranted.

## Test plan
- Reset, then sample: hold `rst` = 1 for 2 cycles, then release; read r1..r31 on both ports with `re` = 1 → all return 0x00000000.
- Write then read:
  - Write r5 = 0xDEADBEEF in cycle N.
  - Cycle N+1: read r5 on port 1 → 0xDEADBEEF.
  - Port 2 reading r6 → 0x00000000.
- Bypass:
  - Cycle N: `we` = 1, `waddr` = 7, `wdata` = 0x12345678, with `raddr1` = `raddr2` = 7 and both enables high → both ports return 0x12345678 in cycle N.
  - r7 held 0xAAAAAAAA before the write.
- r0 protection:
  - Write r0 = 0xFFFFFFFF with `raddr1` = 0 in the same cycle → 0x00000000.
  - Next cycle, read r0 → 0x00000000.
- Read-enable gating: r3 = 0x00000042 and `re2` = 0 with `raddr2` = 3 → `rdata2` = 0x00000000; raise `re2` → 0x00000042.
- Reset mid-stream:
  - r9 = 0x11111111.
  - Then a cycle with `rst` = 1 and `we` = 1, `waddr` = 9, `wdata` = 0x22222222 → `rdata1` = 0 during reset.
  - After `rst` deasserts, r9 reads 0x00000000.
